// File: rtl/mat_host_ctrl.sv
// Host sequencer for the matrix PE array: streams operand beats into RAM A then RAM B,
// pulses the array, waits for its completion edge, then drains the result RAM in order.

module mat_fifo_lane #(
  parameter int VEC_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             wptr,
  input  logic             rptr,
  input  logic [VEC_W-1:0] din,
  output logic [VEC_W-1:0] dout
);
  logic [1:0][VEC_W-1:0] mem;

  // Storage is reset so that m_data reads as zero while the block is held in reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     mem <= '0;
    else if (push) mem[wptr] <= din;
  end

  assign dout = mem[rptr];
endmodule

module mat_host_ctrl #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 32
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic                            ram_we,
  output logic                            ram_sel,
  output logic [3:0]                      ram_waddr,
  output logic [NUM_LANES-1:0][VEC_W-1:0] ram_wdata,
  output logic                            pe_valid,
  input  logic                            pe_stop,
  output logic [3:0]                      res_raddr,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] res_rdata,
  output logic [NUM_LANES-1:0][VEC_W-1:0] m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            m_last,
  output logic                            busy,
  output logic [7:0]                      run_count
);
  // Result RAM has a fixed one-cycle read latency: a single registered stage.
  localparam int STAGES = 0;

  localparam logic [2:0] LOAD_A = 3'd0;
  localparam logic [2:0] LOAD_B = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] READ   = 3'd4;

  typedef struct packed {
    logic                            sel;
    logic [3:0]                      addr;
    logic [NUM_LANES-1:0][VEC_W-1:0] data;
  } ram_wr_t;

  logic [2:0]      state;
  logic [3:0]      cnt;
  logic            rdy_en;
  logic            stop_q;
  logic            we_r;
  ram_wr_t         wr_r;
  logic [4:0]      rd_addr;
  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] last_pipe;
  logic [1:0]      occ;
  logic            wptr;
  logic            rptr;
  logic [1:0]      last_mem;
  logic            accept;
  logic            pop;
  logic            push;
  logic            issue;
  logic            done;
  logic            stop_rise;
  logic [2:0]      in_use;

  // rdy_en keeps s_ready low until the first edge after reset release.
  assign s_ready   = rdy_en && (state == LOAD_A || state == LOAD_B);
  assign accept    = s_valid && s_ready;
  assign stop_rise = pe_stop && !stop_q;
  assign pe_valid  = (state == START);
  assign busy      = !(state == LOAD_A && cnt == 4'd0);

  assign ram_we    = we_r;
  assign ram_sel   = wr_r.sel;
  assign ram_waddr = wr_r.addr;
  assign ram_wdata = wr_r.data;

  assign m_valid   = (occ != 2'd0);
  assign pop       = m_valid && m_ready;
  assign push      = vld_pipe[STAGES];
  assign m_last    = m_valid && last_mem[rptr];
  assign done      = pop && m_last;
  assign res_raddr = rd_addr[3:0];

  // Credit check counts the read already in flight so the 2-entry FIFO never overflows.
  assign in_use = {1'b0, occ} + {2'b00, push};
  assign issue  = (state == READ) && !rd_addr[4] &&
                  ((in_use < 3'd2) || (in_use == 3'd2 && pop));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= LOAD_A;
      cnt       <= '0;
      rdy_en    <= 1'b0;
      stop_q    <= 1'b0;
      run_count <= '0;
    end else begin
      rdy_en <= 1'b1;
      stop_q <= pe_stop;
      if (done)        cnt <= '0;
      else if (accept) cnt <= cnt + 4'd1;
      case (state)
        LOAD_A:  if (accept && cnt == 4'd15) state <= LOAD_B;
        LOAD_B:  if (accept && cnt == 4'd15) state <= START;
        START:   state <= WAIT;
        WAIT:    if (stop_rise) state <= READ;
        READ: begin
          if (done) begin
            state     <= LOAD_A;
            run_count <= run_count + 8'd1;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_r <= 1'b0;
      wr_r <= '0;
    end else begin
      we_r <= accept;
      if (accept) wr_r <= '{sel: (state == LOAD_B), addr: cnt, data: s_data};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr   <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      occ       <= '0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      last_mem  <= '0;
    end else begin
      vld_pipe  <= issue;
      last_pipe <= issue && (rd_addr[3:0] == 4'hf);
      if (done)       rd_addr <= '0;
      else if (issue) rd_addr <= rd_addr + 5'd1;
      if (push) begin
        last_mem[wptr] <= last_pipe[STAGES];
        wptr           <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    mat_fifo_lane #(.VEC_W(VEC_W)) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .push (push),
      .wptr (wptr),
      .rptr (rptr),
      .din  (res_rdata[l]),
      .dout (m_data[l])
    );
  end
endmodule

// File: doc/mat_host_ctrl.md
MAT_HOST_CTRL -- requirements
Module: mat_host_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rstn (asynchronous, active-low).
REQ-002 clk  in  1  system clock.
REQ-003 rstn  in  1  asynchronous active-low reset.
REQ-004 s_data  in  128  input beat; four 32-bit elements, element 0 in bits [31:0].
REQ-005 s_valid  in  1  input beat valid.
REQ-006 s_ready  out  1  input beat accepted when s_valid && s_ready.
REQ-007 ram_we  out  1  operand RAM write strobe.
REQ-008 ram_sel  out  1  operand RAM select: 0 = RAM A, 1 = RAM B.
REQ-009 ram_waddr  out  4  operand RAM word address.
REQ-010 ram_wdata  out  128  operand RAM write data.
REQ-011 pe_valid  out  1  single-cycle start pulse to the PE array.
REQ-012 pe_stop  in  1  PE run complete; level, may stay high between runs.
REQ-013 res_raddr  out  4  result RAM read address.
REQ-014 res_rdata  in  128  result RAM read data, valid exactly 1 cycle after res_raddr is issued.
REQ-015 m_data  out  128  output beat (result word).
REQ-016 m_valid  out  1  output beat valid.
REQ-017 m_ready  in  1  downstream ready.
REQ-018 m_last  out  1  high with the 16th output beat of a run.
REQ-019 busy  out  1  high in any state other than LOAD_A with count 0.
REQ-020 run_count  out  8  completed runs, wraps 255 -> 0.

Function
REQ-021 States SHALL be LOAD_A, LOAD_B, START, WAIT, READ; 4-bit beat counter cnt.
REQ-022 s_ready SHALL be 1 only in LOAD_A/LOAD_B; 0 in START, WAIT, READ.
REQ-023 Accepted beat in LOAD_A SHALL produce, next cycle, ram_we=1, ram_sel=0, ram_waddr=cnt-at-accept, ram_wdata=s_data; LOAD_B identical with ram_sel=1.
REQ-024 ram_we SHALL be 0 in every cycle not following an acceptance; bubbles on s_valid do not advance cnt.
REQ-025 cnt SHALL increment per accepted beat; acceptance at cnt=15 wraps cnt to 0 and moves LOAD_A->LOAD_B, LOAD_B->START.
REQ-026 START SHALL last exactly one cycle with pe_valid=1, then go to WAIT; pe_valid is 0 in all other states.
REQ-027 WAIT SHALL exit to READ only on a rising edge of pe_stop (registered previous sample 0, current sample 1); a pe_stop held high from a prior run SHALL NOT end WAIT.
REQ-028 pe_stop SHALL be ignored outside WAIT; its edge-detect register still samples every cycle.
REQ-029 READ SHALL issue res_raddr 0..15 in order, one per cycle; it issues only while (FIFO occupancy + reads in flight) < 2, or == 2 with a pop in the same cycle.
REQ-030 res_rdata SHALL be captured into a 2-entry output FIFO 1 cycle after issue; m_valid = FIFO not empty; m_data = FIFO head.
REQ-031 m_data and m_last SHALL remain stable while m_valid && !m_ready.
REQ-032 Beats SHALL leave in address order with no loss or duplication; m_last=1 only on the beat from address 15.
REQ-033 The handshake of the m_last beat SHALL return the state to LOAD_A with cnt=0 and increment run_count in the same edge.
REQ-034 With m_ready held 1, all 16 beats SHALL complete within 34 cycles of READ entry.

Reset
REQ-035 On rstn low, asynchronously: state=LOAD_A, cnt=0, FIFO empty, in-flight reads discarded, stop edge register=0, run_count=0.
REQ-036 During reset all outputs SHALL be 0 except s_ready, which rises to 1 on the first clk edge after rstn deasserts.
REQ-037 Reset mid-operation SHALL abandon the run; RAM contents are not cleared; no pe_valid or ram_we is emitted until new beats are accepted.

Verification
REQ-038 Identity run: 32 beats, A and B row i with 1 at element i mod 4 of word 2i+(i/4) -> 16 writes to A addr 0..15, then 16 to B; exactly one pe_valid cycle; pe_stop model rises 20 cycles later; 16 result beats in address order, m_last on beat 16, run_count=1.
REQ-039 Backpressure: m_ready 50% random -> same 16 beats, in order, no duplicates, m_data constant through every stall.
REQ-040 Input bubbles: s_valid low for 3 cycles after beats 5 and 20 -> contiguous addresses, no ram_we during gaps.
REQ-041 Stale stop: pe_stop high through START and 3 WAIT cycles, low 5 cycles, then high -> READ entered only on the cycle after the rising edge.
REQ-042 Reset after 7 output beats -> m_valid=0 immediately, s_ready=1 after 1 edge, run_count=0, no further res_raddr.
REQ-043 Back-to-back runs with m_ready=1 -> run_count=2; each READ phase completes in <=34 cycles.
